// File: rtl/sprite_jump_engine.sv
// Sprite renderer with jump physics and a multi-frame run animation.
// Latency: pixel_on is 2 cycles after hor_reg/ver_reg, and rom_addr is 1 cycle after.
// Backpressure: none. The pipeline is free-running and always accepts the scan position.
//
// Ports:
//   clk, rst        pixel clock, synchronous active-low reset
//   game_run        1 = running, 0 = halt (physics and animation frozen, rendering continues)
//   jump_req        single-cycle jump request
//   frame_tick      one-cycle pulse at the start of vertical blanking; physics step
//   hor_reg/ver_reg current scan column/row
//   rom_data        1-bit sprite ROM output for the registered rom_addr
//   rom_addr        sprite ROM address, held while the scan is outside the sprite box
//   pixel_on        sprite pixel visible at the scan point from two cycles earlier
//   pos_*           sprite bounding box
//   airborne        sprite is rising or falling
// Build option: define DOUBLE_JUMP_EN to allow one extra jump per airborne period.
module sprite_jump_engine #(
    parameter int SPR_W      = 32,
    parameter int SPR_H      = 72,
    parameter int FRAMES     = 2,
    parameter int X_POS      = 100,
    parameter int GROUND_Y   = 480,
    parameter int JUMP_V0    = 20,
    parameter int GRAVITY    = 1,
    parameter int ANIM_TICKS = 6,
    parameter int ADDR_W     = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              game_run,
    input  logic              jump_req,
    input  logic              frame_tick,
    input  logic [10:0]       hor_reg,
    input  logic [9:0]        ver_reg,
    input  logic              rom_data,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              pixel_on,
    output logic [12:0]       pos_x_from,
    output logic [12:0]       pos_x_to,
    output logic [12:0]       pos_y_from,
    output logic [12:0]       pos_y_to,
    output logic              airborne
);

    localparam int FRAME_SZ = SPR_W * SPR_H;
    localparam int AFW = (FRAMES > 1) ? $clog2(FRAMES) : 1;
    localparam int ACW = (ANIM_TICKS > 1) ? $clog2(ANIM_TICKS) : 1;

    typedef enum logic [1:0] {GROUND, RISE, FALL} state_t;

    state_t             state, state_n;
    logic [12:0]        height, height_n;
    logic signed [12:0] vel, vel_n;
    logic [AFW-1:0]     anim_frame, anim_frame_n;
    logic [ACW-1:0]     anim_cnt, anim_cnt_n;
`ifdef DOUBLE_JUMP_EN
    logic               dj_used, dj_used_n;
`endif

    // One extra bit of headroom so that height+vel cannot wrap before the landing test.
    logic signed [13:0] h_sum;
    logic signed [13:0] v_dec;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= GROUND;
            height     <= '0;
            vel        <= '0;
            anim_frame <= '0;
            anim_cnt   <= '0;
`ifdef DOUBLE_JUMP_EN
            dj_used    <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            height     <= height_n;
            vel        <= vel_n;
            anim_frame <= anim_frame_n;
            anim_cnt   <= anim_cnt_n;
`ifdef DOUBLE_JUMP_EN
            dj_used    <= dj_used_n;
`endif
        end
    end

    always_comb begin
        state_n      = state;
        height_n     = height;
        vel_n        = vel;
        anim_frame_n = anim_frame;
        anim_cnt_n   = anim_cnt;
`ifdef DOUBLE_JUMP_EN
        dj_used_n    = dj_used;
`endif
        h_sum = $signed({1'b0, height}) + $signed({vel[12], vel});
        v_dec = $signed({vel[12], vel}) - $signed(14'(GRAVITY));

        case (state)
            GROUND: begin
                if (game_run) begin
                    if (jump_req) begin
                        // A coincident frame_tick only starts the jump; the first
                        // physics step waits for the next tick.
                        state_n      = RISE;
                        vel_n        = 13'(JUMP_V0);
                        anim_frame_n = '0;
                        anim_cnt_n   = '0;
                    end else if (frame_tick) begin
                        if (anim_cnt == ACW'(ANIM_TICKS - 1)) begin
                            anim_cnt_n   = '0;
                            anim_frame_n = (anim_frame == AFW'(FRAMES - 1)) ?
                                           '0 : anim_frame + AFW'(1);
                        end else begin
                            anim_cnt_n = anim_cnt + ACW'(1);
                        end
                    end
                end
            end
            default: begin
                if (game_run) begin
`ifdef DOUBLE_JUMP_EN
                    if (jump_req && !dj_used) begin
                        vel_n     = 13'(JUMP_V0);
                        state_n   = RISE;
                        dj_used_n = 1'b1;
                    end else
`endif
                    if (frame_tick) begin
                        if (h_sum <= 14'sd0) begin
                            height_n = '0;
                            vel_n    = '0;
                            state_n  = GROUND;
`ifdef DOUBLE_JUMP_EN
                            dj_used_n = 1'b0;
`endif
                        end else begin
                            height_n = h_sum[12:0];
                            vel_n    = v_dec[12:0];
                            state_n  = (v_dec > 14'sd0) ? RISE : FALL;
                        end
                    end
                end
            end
        endcase
    end

    assign airborne   = (state == RISE) || (state == FALL);
    assign pos_x_from = 13'(X_POS);
    assign pos_x_to   = 13'(X_POS + SPR_W - 1);
    assign pos_y_from = 13'(GROUND_Y) - height;
    assign pos_y_to   = pos_y_from + 13'(SPR_H - 1);

    // Rendering: stage 1 forms the ROM address, and stage 2 gates the ROM bit with the box flag.
    logic [12:0]       hor_ext, ver_ext, row_off, col_off;
    logic              in_box, d1_in_box;
    logic [ADDR_W-1:0] addr_calc;

    assign hor_ext = {2'b00, hor_reg};
    assign ver_ext = {3'b000, ver_reg};
    assign in_box  = (hor_ext >= pos_x_from) && (hor_ext <= pos_x_to) &&
                     (ver_ext >= pos_y_from) && (ver_ext <= pos_y_to);
    assign row_off = ver_ext - pos_y_from;
    assign col_off = hor_ext - pos_x_from;
    assign addr_calc = ADDR_W'(anim_frame) * ADDR_W'(FRAME_SZ) +
                       ADDR_W'(row_off) * ADDR_W'(SPR_W) + ADDR_W'(col_off);

    always_ff @(posedge clk) begin
        if (!rst) begin
            rom_addr  <= '0;
            d1_in_box <= 1'b0;
            pixel_on  <= 1'b0;
        end else begin
            if (in_box) begin
                rom_addr <= addr_calc;
            end
            d1_in_box <= in_box;
            pixel_on  <= d1_in_box & rom_data;
        end
    end

endmodule

// File: tb/tb_sprite_jump_engine.sv
// Bench for sprite_jump_engine: random and directed stimulus with a reference model and a scoreboard.
// Latency: expected outputs are queued one cycle ahead of the edge that produces them.
// Backpressure: none. The monitor drains every entry that is due on each falling edge.
module tb_sprite_jump_engine;

    logic        clk = 1'b0;
    logic        rst, game_run, jump_req, frame_tick;
    logic [10:0] hor_reg;
    logic [9:0]  ver_reg;
    logic        rom_data;
    logic [12:0] rom_addr;
    logic        pixel_on;
    logic [12:0] pos_x_from, pos_x_to, pos_y_from, pos_y_to;
    logic        airborne;

    always #5 clk = ~clk;

    sprite_jump_engine dut (
        .clk(clk), .rst(rst), .game_run(game_run), .jump_req(jump_req),
        .frame_tick(frame_tick), .hor_reg(hor_reg), .ver_reg(ver_reg),
        .rom_data(rom_data), .rom_addr(rom_addr), .pixel_on(pixel_on),
        .pos_x_from(pos_x_from), .pos_x_to(pos_x_to), .pos_y_from(pos_y_from),
        .pos_y_to(pos_y_to), .airborne(airborne)
    );

    // The sprite ROM is modelled as a fixed pseudo-random bit pattern of its address.
    function automatic logic rom_fn(input logic [12:0] a);
        return a[0] ^ a[3] ^ a[5] ^ a[8] ^ a[11] ^ (a[1] & a[6]);
    endfunction

    assign rom_data = rom_fn(rom_addr);

    typedef struct {
        int          due;
        logic [12:0] pyf;
        logic        air;
        logic [12:0] addr;
        logic        pix;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passed = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // The reference model tracks the sprite as whole numbers: height, velocity, and the animation counters.
    int m_h = 0, m_v = 0, m_af = 0, m_ac = 0, m_addr = 0;
    bit m_air = 0, m_dj = 0, m_d1 = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv)
            $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc, act, expv);
        else
            passed++;
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            chk("due_cycle", 32'(e.due), 32'(cyc));
            chk("pos_x_from", 32'(pos_x_from), 32'd100);
            chk("pos_x_to", 32'(pos_x_to), 32'd131);
            chk("pos_y_from", 32'(pos_y_from), 32'(e.pyf));
            chk("pos_y_to", 32'(pos_y_to), 32'(e.pyf) + 32'd71);
            chk("airborne", 32'(airborne), 32'(e.air));
            chk("rom_addr", 32'(rom_addr), 32'(e.addr));
            chk("pixel_on", 32'(pixel_on), 32'(e.pix));
        end
    end

    task automatic cycle(input bit r, input bit gr, input bit j, input bit t,
                         input int hx, input int vy);
        exp_t e;
        int   pyf, na, hn;
        bit   ib, pix;
        @(posedge clk);
        #1;
        rst = r; game_run = gr; jump_req = j; frame_tick = t;
        hor_reg = 11'(hx); ver_reg = 10'(vy);
        pyf = 480 - m_h;
        ib  = (hx >= 100) && (hx <= 131) && (vy >= pyf) && (vy <= pyf + 71);
        na  = (m_af * 32 * 72 + (vy - pyf) * 32 + (hx - 100)) % 8192;
        pix = m_d1 & rom_fn(13'(m_addr));
        if (!r) begin
            m_h = 0; m_v = 0; m_af = 0; m_ac = 0; m_air = 0; m_dj = 0;
            m_d1 = 0; m_addr = 0; pix = 0;
        end else begin
            m_d1 = ib;
            if (ib) m_addr = na;
            if (gr) begin
                if (!m_air) begin
                    if (j) begin
                        m_air = 1; m_v = 20; m_af = 0; m_ac = 0;
                    end else if (t) begin
                        if (m_ac == 5) begin m_ac = 0; m_af = (m_af + 1) % 2; end
                        else m_ac = m_ac + 1;
                    end
                end else begin
`ifdef DOUBLE_JUMP_EN
                    if (j && !m_dj) begin
                        m_v = 20; m_dj = 1;
                    end else
`endif
                    if (t) begin
                        hn = m_h + m_v;
                        if (hn <= 0) begin
                            m_h = 0; m_v = 0; m_air = 0; m_dj = 0;
                        end else begin
                            m_h = hn; m_v = m_v - 1;
                        end
                    end
                end
            end
        end
        e.due  = cyc + 1;
        e.pyf  = 13'(480 - m_h);
        e.air  = m_air;
        e.addr = 13'(m_addr);
        e.pix  = pix;
        q.push_back(e);
    endtask

    // Most scan points land on or near the sprite box, so the address path is exercised often.
    task automatic rand_scan(output int hx, output int vy);
        if ($urandom_range(0, 3) != 0) begin
            hx = int'($urandom_range(95, 136));
            vy = (480 - m_h) + int'($urandom_range(0, 80)) - 4;
        end else begin
            hx = int'($urandom_range(0, 1023));
            vy = int'($urandom_range(0, 599));
        end
    endtask

    task automatic run(input int n, input bit gr, input bit j_first, input int tick_every);
        int hx, vy;
        for (int i = 0; i < n; i++) begin
            rand_scan(hx, vy);
            cycle(1'b1, gr, (i == 0) && j_first, (i % tick_every) == tick_every - 1, hx, vy);
        end
    endtask

    initial begin
        int hx, vy;
        bit r, gr, j, t;
        rst = 1'b0; game_run = 1'b0; jump_req = 1'b0; frame_tick = 1'b0;
        hor_reg = '0; ver_reg = '0;

        repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        // Idle running: animation steps to frame 1 after six ticks.
        run(14, 1'b1, 1'b0, 2);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 100, 480);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 132, 480);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 131, 551);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 99, 500);
        repeat (3) cycle(1'b1, 1'b1, 1'b0, 1'b0, 110, 520);
        // A full jump, then a coincident jump and tick from the ground.
        run(100, 1'b1, 1'b1, 2);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 105, 490);
        run(90, 1'b1, 1'b0, 2);
        // A halt at height 39 with an ignored jump request, then resume; then a second jump at height 57.
        run(4, 1'b1, 1'b1, 2);
        run(20, 1'b0, 1'b1, 2);
        run(2, 1'b1, 1'b0, 2);
        run(1, 1'b1, 1'b1, 2);
        run(4, 1'b1, 1'b0, 2);
        run(1, 1'b1, 1'b1, 2);
        run(12, 1'b1, 1'b0, 2);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 100, 480);
        run(10, 1'b1, 1'b0, 2);

        for (int i = 0; i < 15000; i++) begin
            r  = ($urandom_range(0, 1999) != 0);
            gr = ($urandom_range(0, 9) != 0);
            j  = ($urandom_range(0, 39) == 0);
            t  = ($urandom_range(0, 2) == 0);
            rand_scan(hx, vy);
            cycle(r, gr, j, t, hx, vy);
        end

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
